// File: rtl/feed_pop_scheduler_pkg.sv
// Shared types and helpers for the feeder pop scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package feed_sched_pkg;

    // Scheduler FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_CLEAR = 3'd4
    } feed_state_e;

    // Bits needed to count from 0 up to max_val inclusive (never less than 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/feed_pop_scheduler_if.sv
// Control/lane bundle between core FSM, pop scheduler and feeder lanes.
// Latency: n/a (wires only).
// Backpressure: i_pipeline_en stalls the scheduler; no other flow control.
interface feed_pop_scheduler_if #(
    parameter int N_LANES = 8,
    parameter int CNT_W   = 16
);
    logic               i_start;
    logic               i_abort;
    logic [CNT_W-1:0]   i_npops;
    logic               i_pipeline_en;
    logic [N_LANES-1:0] i_lane_empty;
    logic [N_LANES-1:0] o_pop_en;
    logic               o_clearfifo;
    logic               o_busy;
    logic               o_done;
    logic               o_underrun;

    // Core control side: drives tile commands, observes status.
    modport master (
        output i_start, i_abort, i_npops, i_pipeline_en, i_lane_empty,
        input  o_pop_en, o_clearfifo, o_busy, o_done, o_underrun
    );

    // Scheduler side.
    modport slave (
        input  i_start, i_abort, i_npops, i_pipeline_en, i_lane_empty,
        output o_pop_en, o_clearfifo, o_busy, o_done, o_underrun
    );
endinterface

// File: rtl/feed_pop_scheduler_skew_shreg.sv
// Enabled serial-in/parallel-out shift register producing a one-cycle-per-lane diagonal.
// Latency: 1 enabled cycle from ser_in to par_out[0], +1 per lane after that.
// Backpressure: shift_en low holds contents; clr has priority over shifting.
module feed_skew_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out
);

    // Shift toward the high lanes on enabled cycles; synchronous clear wins.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            par_out <= '0;
        end else if (clr) begin
            par_out <= '0;
        end else if (shift_en) begin
            par_out <= {par_out[WIDTH-2:0], ser_in};
        end
    end

endmodule

// File: rtl/feed_pop_scheduler.sv
// Sequences skewed per-lane FIFO pops for one feeder side, counts pops, flags underrun, clears FIFOs.
// Latency: IDLE->FILL 1 cycle, first lane-0 pop 1 enabled cycle after RUN entry, npops+N_LANES-1 enabled cycles of pops.
// Backpressure: i_pipeline_en low freezes pop pattern and counter; i_lane_empty gates FILL->RUN only.
module feed_pop_scheduler
    import feed_sched_pkg::*;
#(
    parameter int N_LANES = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    feed_pop_scheduler_if.slave  bus
);

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_FILL  = S_FILL;
    localparam logic [2:0] ST_RUN   = S_RUN;
    localparam logic [2:0] ST_DRAIN = S_DRAIN;
    localparam logic [2:0] ST_CLEAR = S_CLEAR;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   npops_q;
    logic               underrun;
    logic [N_LANES-1:0] skew;

    logic start_acc;
    logic head;
    logic active;
    logic run_last;
    logic shift_en;
    logic shift_in;
    logic skew_clr;
    logic underrun_hit;

    assign start_acc = (state == ST_IDLE) && bus.i_start;
    assign head      = (cnt < npops_q);
    assign cnt_inc   = cnt + CNT_W'(1);
    assign active    = (state == ST_RUN) || (state == ST_DRAIN);
    // Counter only advances on enabled cycles, so the last pop and a stall never coincide.
    assign run_last  = bus.i_pipeline_en && head && (cnt_inc == npops_q);

    // New pops enter lane 0 only while RUN still owes pops; DRAIN just flushes the diagonal.
    assign shift_en  = active && bus.i_pipeline_en;
    assign shift_in  = (state == ST_RUN) && head;
    // Zero the diagonal on the way into CLEAR so no pop overlaps the FIFO clear.
    assign skew_clr  = (state_nxt == ST_CLEAR) || (state == ST_CLEAR);

    assign underrun_hit = active && bus.i_pipeline_en && ((skew & bus.i_lane_empty) != '0);

    // Next-state selection; abort overrides every other transition from busy states.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.i_start) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (bus.i_abort)                 state_nxt = ST_CLEAR;
                else if (npops_q == '0)          state_nxt = ST_CLEAR;
                else if (bus.i_lane_empty == '0) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.i_abort)   state_nxt = ST_CLEAR;
                else if (run_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.i_abort)     state_nxt = ST_CLEAR;
                else if (skew == '0) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the tile length on start and count lane-0 pops during RUN.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt     <= '0;
            npops_q <= '0;
        end else if (start_acc) begin
            cnt     <= '0;
            npops_q <= bus.i_npops;
        end else if ((state == ST_RUN) && bus.i_pipeline_en && head) begin
            cnt     <= cnt_inc;
        end
    end

    // Sticky underrun flag, rearmed by the next accepted start.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            underrun <= 1'b0;
        end else if (start_acc) begin
            underrun <= 1'b0;
        end else if (underrun_hit) begin
            underrun <= 1'b1;
        end
    end

    feed_skew_shreg #(
        .WIDTH (N_LANES)
    ) u_skew (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .shift_en (shift_en),
        .clr      (skew_clr),
        .ser_in   (shift_in),
        .par_out  (skew)
    );

    // All outputs are decodes of registers; nothing flows combinationally from inputs.
    assign bus.o_pop_en    = skew;
    assign bus.o_clearfifo = (state == ST_CLEAR);
    assign bus.o_done      = (state == ST_CLEAR);
    assign bus.o_busy      = (state != ST_IDLE);
    assign bus.o_underrun  = underrun;

endmodule

// File: tb/tb_feed_pop_scheduler.sv
// Directed bench for feed_pop_scheduler with a per-cycle expected-output scoreboard.
// Latency: expectations are pushed when a cycle's stimulus is driven, popped one cycle later.
// Backpressure: stalls are exercised through i_pipeline_en.
module tb_feed_pop_scheduler;

    localparam int NL = 4;
    localparam int CW = 8;

    logic clk;
    logic rstn;

    feed_pop_scheduler_if #(.N_LANES(NL), .CNT_W(CW)) bus ();

    feed_pop_scheduler #(
        .N_LANES (NL),
        .CNT_W   (CW)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0] pop;
        logic          clr;
        logic          done;
        logic          busy;
        logic          ur;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_lat = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycles from the start drive to the observed o_done pulse.
    always @(negedge clk) begin
        if (bus.o_done === 1'b1) done_lat = cyc - start_cyc;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [NL-1:0] pop, input logic clr, input logic done,
                        input logic busy, input logic ur);
        exp_t e;
        e.pop = pop; e.clr = clr; e.done = done; e.busy = busy; e.ur = ur;
        exp_q.push_back(e);
    endtask

    task automatic check_front(input string tag);
        exp_t e;
        chk({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!$isunknown(e.pop)) chk({tag, "_pop_en"}, 32'(bus.o_pop_en), 32'(e.pop));
            chk({tag, "_clearfifo"}, 32'(bus.o_clearfifo), 32'(e.clr));
            chk({tag, "_done"},      32'(bus.o_done),      32'(e.done));
            chk({tag, "_busy"},      32'(bus.o_busy),      32'(e.busy));
            chk({tag, "_underrun"},  32'(bus.o_underrun),  32'(e.ur));
        end
    endtask

    // Lane k pops on enabled steps k+1 .. k+p counted from RUN entry.
    function automatic logic [NL-1:0] model_pop(input int t, input int p);
        logic [NL-1:0] v;
        v = '0;
        for (int k = 0; k < NL; k++) v[k] = (t >= k + 1) && (t <= k + p);
        return v;
    endfunction

    // One tile, lockstep: drive a cycle's inputs, push what must appear, step, compare.
    task automatic run_tile(input int p, input int stall_t, input int stall_n, input int fill_hold,
                            input int empty_t, input int abort_t, input int start_t);
        int t;
        int stalls;
        logic ur;
        logic [NL-1:0] cur;
        ur = 1'b0;
        done_lat = -1;
        start_cyc = cyc;
        bus.i_start = 1'b1;
        bus.i_npops = CW'(p);
        bus.i_pipeline_en = 1'b1;
        bus.i_lane_empty = (fill_hold > 0) ? 4'b0100 : 4'b0000;
        push('0, 1'b0, 1'b0, 1'b1, ur);
        step();
        bus.i_start = 1'b0;
        bus.i_npops = 8'hFF;
        check_front("fill");
        for (int i = 0; i < fill_hold; i++) begin
            push('0, 1'b0, 1'b0, 1'b1, ur);
            step();
            check_front("fill_hold");
        end
        bus.i_lane_empty = '0;
        if (p == 0) begin
            push('0, 1'b1, 1'b1, 1'b1, ur); step(); check_front("clear");
            push('0, 1'b0, 1'b0, 1'b0, ur); step(); check_front("idle");
            return;
        end
        push('0, 1'b0, 1'b0, 1'b1, ur);
        step();
        check_front("run_entry");
        t = 0;
        stalls = 0;
        while (t < NL + p) begin
            bus.i_lane_empty = '0;
            bus.i_start = 1'b0;
            if (t == abort_t) begin
                bus.i_abort = 1'b1;
                push('x, 1'b1, 1'b1, 1'b1, ur);
                step();
                bus.i_abort = 1'b0;
                check_front("abort_clear");
                push('0, 1'b0, 1'b0, 1'b0, ur);
                step();
                check_front("abort_idle");
                return;
            end
            if (t == start_t) begin
                bus.i_start = 1'b1;
                bus.i_npops = 8'd7;
            end
            if (t == stall_t && stalls < stall_n) begin
                bus.i_pipeline_en = 1'b0;
                stalls++;
            end else begin
                bus.i_pipeline_en = 1'b1;
                if (t == empty_t) begin
                    bus.i_lane_empty = 4'b0100;
                    cur = model_pop(t, p);
                    if (cur[2]) ur = 1'b1;
                end
                t++;
            end
            push(model_pop(t, p), 1'b0, 1'b0, 1'b1, ur);
            step();
            check_front("skew");
        end
        bus.i_lane_empty = '0;
        bus.i_start = 1'b0;
        bus.i_pipeline_en = 1'b1;
        push('0, 1'b1, 1'b1, 1'b1, ur); step(); check_front("clear");
        push('0, 1'b0, 1'b0, 1'b0, ur); step(); check_front("idle");
    endtask

    initial begin
        rstn = 1'b0;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_npops = '0;
        bus.i_pipeline_en = 1'b0;
        bus.i_lane_empty = '0;
        step();
        step();
        chk("rst_pop_en",    32'(bus.o_pop_en),    32'h0);
        chk("rst_clearfifo", 32'(bus.o_clearfifo), 32'h0);
        chk("rst_busy",      32'(bus.o_busy),      32'h0);
        chk("rst_done",      32'(bus.o_done),      32'h0);
        chk("rst_underrun",  32'(bus.o_underrun),  32'h0);
        rstn = 1'b1;
        step();

        // Basic tile, then same tile with a 2-cycle stall while 0011 is showing.
        run_tile(3, -1, 0, 0, -1, -1, -1);
        chk("done_lat_p3", done_lat, 10);
        run_tile(3, 2, 2, 0, -1, -1, -1);
        chk("done_lat_stall", done_lat, 12);

        // Zero-length tile goes FILL -> CLEAR.
        run_tile(0, -1, 0, 0, -1, -1, -1);
        chk("done_lat_p0", done_lat, 2);

        // Held in FILL by a non-empty lane, then underrun on lane 2; sticky through done.
        run_tile(3, -1, 0, 3, 3, -1, -1);
        step();
        chk("underrun_sticky_idle", 32'(bus.o_underrun), 32'h1);
        // Next accepted start rearms underrun (expected 0 from the fill cycle on).
        run_tile(1, -1, 0, 0, -1, -1, -1);
        chk("done_lat_p1", done_lat, 8);

        // Start ignored mid-RUN, then abort while 0111 is showing.
        run_tile(3, -1, 0, 0, -1, 3, 1);

        // Asynchronous reset in the middle of RUN.
        bus.i_start = 1'b1;
        bus.i_npops = 8'd5;
        bus.i_pipeline_en = 1'b1;
        step();
        bus.i_start = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_pop_en", 32'(bus.o_pop_en), 32'h3);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_pop_en",    32'(bus.o_pop_en),    32'h0);
        chk("mid_rst_clearfifo", 32'(bus.o_clearfifo), 32'h0);
        chk("mid_rst_busy",      32'(bus.o_busy),      32'h0);
        chk("mid_rst_done",      32'(bus.o_done),      32'h0);
        step();
        chk("mid_rst_hold_clearfifo", 32'(bus.o_clearfifo), 32'h0);
        rstn = 1'b1;
        step();
        chk("post_rst_busy", 32'(bus.o_busy), 32'h0);
        run_tile(2, -1, 0, 0, -1, -1, -1);
        chk("done_lat_p2", done_lat, 9);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
